seq_calc_core: RTL and testbench

- Parametrised, clocked successor to the board-level 4-bit calculator datapath.
- Latches two WIDTH-bit operands on a start strobe and computes one of 12 operations across three modes: arithmetic, logical and comparison.
- Multiply and divide are iterative over multiple cycles.
- Owns the MODE register, driven by synchronised, edge-detected pushbuttons.
- Feeds the seven-segment/LED display layer through a start/busy/done handshake.

---
 rtl/seq_calc_core.sv | 195 +++++++++++++++++++
 tb/tb_seq_calc_core.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_calc_core.sv
// Clocked calculator datapath: 12 operations over 3 modes, iterative multiply/divide,
// mode register driven by synchronised, edge-detected pushbuttons.
module seq_calc_core #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           key,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [1:0]           operation,
    input  logic                 start,
    output logic [1:0]           mode,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 overflow,
    output logic                 neg,
    output logic                 div0
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                  state_q, state_d;
    logic [1:0][SYNC_STAGES-1:0] sync_q;
    logic [1:0]              key_prev_q, key_s, press;
    logic [1:0]              mode_q, mode_d;
    logic [WIDTH-1:0]        x_q, x_d, y_q, y_d;
    logic                    is_div_q, is_div_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2*WIDTH-1:0]      acc_q, acc_d;
    logic [2*WIDTH-1:0]      result_q, result_d;
    logic                    ovf_q, ovf_d, neg_q, neg_d, div0_q, div0_d;

    logic [WIDTH:0]          sum;
    logic [WIDTH:0]          mul_sum;
    logic [2*WIDTH-1:0]      mul_next;
    logic [WIDTH:0]          div_sh;
    logic                    div_ge;
    logic [WIDTH-1:0]        div_sub;
    logic [2*WIDTH-1:0]      div_next;

    // Buttons are active-low; a press is a falling edge of the synchronised level.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            key_s[i] = sync_q[i][SYNC_STAGES-1];
        end
        press = key_prev_q & ~key_s;
        mode_d = mode_q;
        if (press[1]) begin
            mode_d = 2'd0;
        end else if (press[0]) begin
            mode_d = mode_q + 2'd1;
        end
    end

    // Multiply: acc = {partial, multiplier}, shift right one bit per iteration.
    // Divide:   acc = {remainder, dividend/quotient}, shift left one bit per iteration.
    always_comb begin
        sum      = {1'b0, x} + {1'b0, y};
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? x_q : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = div_sh >= {1'b0, y_q};
        div_sub  = div_sh[WIDTH-1:0] - y_q;
        div_next = {(div_ge ? div_sub : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_d      = x;
                    y_d      = y;
                    is_div_d = operation[0];
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    neg_d    = 1'b0;
                    div0_d   = 1'b0;
                    state_d  = StDone;
                    case (mode_q)
                        2'd0: begin
                            case (operation)
                                2'd0: begin
                                    result_d = {{(WIDTH-1){1'b0}}, sum};
                                    ovf_d    = sum[WIDTH];
                                end
                                2'd1: begin
                                    result_d = {{WIDTH{1'b0}}, ((x < y) ? (y - x) : (x - y))};
                                    neg_d    = x < y;
                                end
                                2'd2: begin
                                    acc_d   = {{WIDTH{1'b0}}, y};
                                    state_d = StCalc;
                                end
                                default: begin
                                    if (y == '0) begin
                                        result_d = '1;
                                        div0_d   = 1'b1;
                                    end else begin
                                        acc_d   = {{WIDTH{1'b0}}, x};
                                        state_d = StCalc;
                                    end
                                end
                            endcase
                        end
                        2'd1: begin
                            case (operation)
                                2'd0:    result_d = {{WIDTH{1'b0}}, x & y};
                                2'd1:    result_d = {{WIDTH{1'b0}}, x | y};
                                2'd2:    result_d = {{WIDTH{1'b0}}, x ^ y};
                                default: result_d = {{WIDTH{1'b0}}, ~x};
                            endcase
                        end
                        2'd2: begin
                            case (operation)
                                2'd0:    result_d = {{(2*WIDTH-1){1'b0}}, x == y};
                                2'd1:    result_d = {{(2*WIDTH-1){1'b0}}, x < y};
                                2'd2:    result_d = {{(2*WIDTH-1){1'b0}}, x > y};
                                default: result_d = {{WIDTH{1'b0}}, ((x > y) ? x : y)};
                            endcase
                        end
                        default: result_d = '0;
                    endcase
                end
            end
            StCalc: begin
                cnt_d = cnt_q + CW'(1);
                acc_d = is_div_q ? div_next : mul_next;
                if (cnt_q == LastIter) begin
                    result_d = acc_d;
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '1;
            key_prev_q <= '1;
            mode_q     <= 2'd0;
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            is_div_q   <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            neg_q      <= 1'b0;
            div0_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], key[i]};
            end
            key_prev_q <= key_s;
            mode_q     <= mode_d;
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            is_div_q   <= is_div_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            neg_q      <= neg_d;
            div0_q     <= div0_d;
        end
    end

    assign mode     = mode_q;
    assign busy     = (state_q == StCalc);
    assign done     = (state_q == StDone);
    assign result   = result_q;
    assign overflow = ovf_q;
    assign neg      = neg_q;
    assign div0     = div0_q;

endmodule

// File: tb/tb_seq_calc_core.sv
// Directed bench for seq_calc_core at WIDTH=4: one task per feature, inline checks.
module tb_seq_calc_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] key;
    logic [3:0] x, y;
    logic [1:0] operation;
    logic       start;
    logic [1:0] mode;
    logic       busy, done;
    logic [7:0] result;
    logic       overflow, neg, div0;

    int total = 0;
    int bad   = 0;

    seq_calc_core #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .x         (x),
        .y         (y),
        .operation (operation),
        .start     (start),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .neg       (neg),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    // Pulses START for one cycle; lat = cycles until DONE (-1 on timeout).
    task automatic run_op(input logic [3:0] xv, input logic [3:0] yv, input logic [1:0] opv,
                          output int lat, output int bcnt);
        @(negedge clk);
        x = xv; y = yv; operation = opv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        bcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic press(input int k, input int hold);
        @(negedge clk);
        key[k] = 1'b0;
        repeat (hold) @(negedge clk);
        key[k] = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic set_mode(input int m);
        press(1, 2);
        for (int i = 0; i < m; i++) press(0, 2);
    endtask

    task automatic test_reset;
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d want=0", mode); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h want=00", result); end
        total++; if ({overflow, neg, div0} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {overflow, neg, div0});
        end
    endtask

    task automatic test_add;
        int lat, bc;
        run_op(4'd9, 4'd8, 2'd0, lat, bc);
        total++; if (lat !== 1) begin bad++; $display("FAIL add_latency got=%0d want=1", lat); end
        total++; if (result !== 8'h11) begin bad++; $display("FAIL add_result got=%h want=11", result); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL add_ovf got=%b want=1", overflow); end
        total++; if (neg !== 1'b0) begin bad++; $display("FAIL add_neg got=%b want=0", neg); end
    endtask

    task automatic test_sub;
        int lat, bc;
        run_op(4'd3, 4'd7, 2'd1, lat, bc);
        total++; if (result !== 8'h04) begin bad++; $display("FAIL sub_neg_result got=%h want=04", result); end
        total++; if (neg !== 1'b1) begin bad++; $display("FAIL sub_neg_flag got=%b want=1", neg); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL sub_ovf_clear got=%b want=0", overflow); end
        run_op(4'd7, 4'd3, 2'd1, lat, bc);
        total++; if (result !== 8'h04) begin bad++; $display("FAIL sub_pos_result got=%h want=04", result); end
        total++; if (neg !== 1'b0) begin bad++; $display("FAIL sub_pos_flag got=%b want=0", neg); end
    endtask

    task automatic test_mul;
        int lat = -1, bcnt = 0, dcnt = 0;
        logic [7:0] res = '0;
        @(negedge clk);
        x = 4'd15; y = 4'd15; operation = 2'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 2) begin start = 1'b1; x = 4'd1; y = 4'd1; end
            if (i == 3) start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat < 0) begin lat = i; res = result; end
            end
            @(negedge clk);
        end
        total++; if (bcnt !== 4) begin bad++; $display("FAIL mul_busy_cycles got=%0d want=4", bcnt); end
        total++; if (lat !== 5) begin bad++; $display("FAIL mul_latency got=%0d want=5", lat); end
        total++; if (res !== 8'hE1) begin bad++; $display("FAIL mul_result got=%h want=e1", res); end
        total++; if (dcnt !== 1) begin bad++; $display("FAIL mul_done_count got=%0d want=1", dcnt); end
    endtask

    task automatic test_div;
        int lat, bc;
        run_op(4'd13, 4'd4, 2'd3, lat, bc);
        total++; if (lat !== 5) begin bad++; $display("FAIL div_latency got=%0d want=5", lat); end
        total++; if (result !== 8'h13) begin bad++; $display("FAIL div_result got=%h want=13", result); end
        total++; if (div0 !== 1'b0) begin bad++; $display("FAIL div_div0 got=%b want=0", div0); end
        run_op(4'd13, 4'd0, 2'd3, lat, bc);
        total++; if (lat !== 1) begin bad++; $display("FAIL div0_latency got=%0d want=1", lat); end
        total++; if (bc !== 0) begin bad++; $display("FAIL div0_busy got=%0d want=0", bc); end
        total++; if (result !== 8'hFF) begin bad++; $display("FAIL div0_result got=%h want=ff", result); end
        total++; if (div0 !== 1'b1) begin bad++; $display("FAIL div0_flag got=%b want=1", div0); end
    endtask

    task automatic test_logic;
        int lat, bc;
        logic [7:0] exp [4] = '{8'h08, 8'h0E, 8'h06, 8'h03};
        set_mode(1);
        for (int op = 0; op < 4; op++) begin
            run_op(4'hC, 4'hA, 2'(op), lat, bc);
            total++;
            if (result !== exp[op] || lat !== 1) begin
                bad++;
                $display("FAIL logic_op%0d got=%h lat=%0d want=%h lat=1", op, result, lat, exp[op]);
            end
        end
    endtask

    task automatic test_compare;
        int lat, bc;
        logic [3:0] xs [4] = '{4'd5, 4'd3, 4'd3, 4'd5};
        logic [3:0] ys [4] = '{4'd5, 4'd7, 4'd7, 4'd9};
        logic [7:0] exp [4] = '{8'h01, 8'h01, 8'h00, 8'h09};
        set_mode(2);
        for (int op = 0; op < 4; op++) begin
            run_op(xs[op], ys[op], 2'(op), lat, bc);
            total++;
            if (result !== exp[op]) begin
                bad++; $display("FAIL cmp_op%0d got=%h want=%h", op, result, exp[op]);
            end
        end
    endtask

    task automatic test_reserved;
        int lat, bc;
        set_mode(3);
        run_op(4'd9, 4'd8, 2'd0, lat, bc);
        total++; if (lat !== 1) begin bad++; $display("FAIL rsv_latency got=%0d want=1", lat); end
        total++; if (result !== 8'h00 || overflow !== 1'b0) begin
            bad++; $display("FAIL rsv_result got=%h ovf=%b want=00 ovf=0", result, overflow);
        end
    endtask

    task automatic test_keys;
        logic [1:0] exp [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        press(1, 2);
        for (int i = 0; i < 4; i++) begin
            press(0, 2);
            total++;
            if (mode !== exp[i]) begin bad++; $display("FAIL key_step%0d got=%0d want=%0d", i, mode, exp[i]); end
        end
        press(0, 100);
        total++; if (mode !== 2'd1) begin bad++; $display("FAIL key_hold got=%0d want=1", mode); end
        press(0, 2);
        @(negedge clk);
        key = 2'b00;
        repeat (3) @(negedge clk);
        key = 2'b11;
        repeat (5) @(negedge clk);
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL key_both got=%0d want=0", mode); end
    endtask

    task automatic test_mode_during_mul;
        int lat = -1;
        set_mode(0);
        @(negedge clk);
        x = 4'd13; y = 4'd11; operation = 2'd2; start = 1'b1; key[0] = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) key[0] = 1'b1;
            if (done) begin lat = i; break; end
            @(negedge clk);
        end
        total++; if (lat !== 5 || result !== 8'h8F) begin
            bad++; $display("FAIL mul_mode_change got=%h lat=%0d want=8f lat=5", result, lat);
        end
        repeat (3) @(negedge clk);
        total++; if (mode !== 2'd1) begin bad++; $display("FAIL mul_mode_value got=%0d want=1", mode); end
    endtask

    task automatic test_reset_mid_div;
        int lat, bc, dcnt = 0;
        set_mode(0);
        @(negedge clk);
        x = 4'd13; y = 4'd4; operation = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({busy, done, overflow, neg, div0} !== 5'b0 || result !== 8'h00 || mode !== 2'd0) begin
            bad++; $display("FAIL midreset_outputs got=busy%b done%b res=%h flags=%b want all 0",
                            busy, done, result, {overflow, neg, div0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        total++; if (dcnt !== 0) begin bad++; $display("FAIL midreset_done got=%0d want=0", dcnt); end
        set_mode(2);
        run_op(4'd5, 4'd9, 2'd3, lat, bc);
        total++; if (lat !== 1 || result !== 8'h09) begin
            bad++; $display("FAIL post_reset_max got=%h lat=%0d want=09 lat=1", result, lat);
        end
    endtask

    initial begin
        rst_n = 1'b0; key = 2'b11; x = '0; y = '0; operation = '0; start = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_add;
        test_sub;
        test_mul;
        test_div;
        test_reset_mid_div;
        test_logic;
        test_compare;
        test_reserved;
        test_keys;
        test_mode_during_mul;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
